// File: rtl/fetch_prefetch_buffer.sv
// Instruction fetch front end: owns the fetch PC, issues pipelined imem
// requests under a credit limit, tracks in-flight PCs, and queues returned
// instructions with their PCs for the decode stage.
module fetch_prefetch_buffer #(
  parameter int                       DATA_WIDTH      = 32,
  parameter int                       ADDRESS_WIDTH   = 32,
  parameter int                       DEPTH           = 4,
  parameter int                       MAX_OUTSTANDING = 2,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pc_src_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
  input  logic                     stall_d,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]    imem_rsp_data,
  output logic                     instr_valid_d,
  output logic [DATA_WIDTH-1:0]    instr_d,
  output logic [ADDRESS_WIDTH-1:0] pc_d,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_d
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [DATA_WIDTH-1:0]    NOP  = DATA_WIDTH'(32'h0000_0013);
  localparam logic [ADDRESS_WIDTH-1:0] FOUR = ADDRESS_WIDTH'(4);

  logic [ADDRESS_WIDTH-1:0] fetch_pc;
  logic [OW-1:0]            outstanding;
  logic [OW-1:0]            drop_cnt;
  logic [OW-1:0]            outstanding_after_rsp;

  logic [ADDRESS_WIDTH-1:0] inflight_pc [MAX_OUTSTANDING];
  logic [IW-1:0]            inflight_wr;
  logic [IW-1:0]            inflight_rd;

  logic [DATA_WIDTH-1:0]    fifo_instr [DEPTH];
  logic [ADDRESS_WIDTH-1:0] fifo_pc    [DEPTH];
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [CW-1:0]            fifo_count;

  logic credit_ok;
  logic issue_ok;
  logic accept;
  logic push;
  logic pop;
  logic unused_target_lsbs;

  assign unused_target_lsbs = ^pc_target_e[1:0];

  function automatic logic [IW-1:0] inflight_next(input logic [IW-1:0] p);
    return (p == IW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Request gating, handshake, FIFO push/pop decisions.
  always_comb begin
    credit_ok             = (32'(fifo_count) + 32'(outstanding)) < 32'(DEPTH);
    issue_ok              = outstanding < OW'(MAX_OUTSTANDING);
    imem_req_valid        = !reset && !pc_src_e && issue_ok && credit_ok;
    imem_req_addr         = fetch_pc;
    accept                = imem_req_valid && imem_req_ready;
    push                  = imem_rsp_valid && (drop_cnt == '0) && !pc_src_e;
    pop                   = instr_valid_d && !stall_d && !pc_src_e;
    outstanding_after_rsp = outstanding - OW'(imem_rsp_valid);
  end

  // Head of the FIFO drives decode; NOP and zero PCs when empty.
  always_comb begin
    instr_valid_d = (fifo_count != '0);
    instr_d       = NOP;
    pc_d          = '0;
    pc_plus4_d    = '0;
    if (instr_valid_d) begin
      instr_d    = fifo_instr[rd_ptr];
      pc_d       = fifo_pc[rd_ptr];
      pc_plus4_d = fifo_pc[rd_ptr] + FOUR;
    end
  end

  // Fetch PC, outstanding/drop counters and in-flight queue pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      inflight_wr <= '0;
      inflight_rd <= '0;
    end else begin
      if (pc_src_e) begin
        fetch_pc <= {pc_target_e[ADDRESS_WIDTH-1:2], 2'b00};
      end else if (accept) begin
        fetch_pc <= fetch_pc + FOUR;
      end
      if (accept) begin
        inflight_wr <= inflight_next(inflight_wr);
      end
      if (imem_rsp_valid) begin
        inflight_rd <= inflight_next(inflight_rd);
      end
      outstanding <= outstanding + OW'(accept) - OW'(imem_rsp_valid);
      // A redirect overwrites any pending drops: everything still in flight
      // after this cycle's response belongs to the abandoned path.
      if (pc_src_e) begin
        drop_cnt <= outstanding_after_rsp;
      end else if (imem_rsp_valid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  // FIFO occupancy and pointers; redirect empties the queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (pc_src_e) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // Storage arrays; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (accept) begin
      inflight_pc[inflight_wr] <= fetch_pc;
    end
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr]    <= inflight_pc[inflight_rd];
    end
  end

  a_no_push_full : assert property (@(posedge clk) disable iff (reset)
    !(push && (fifo_count == CW'(DEPTH))));
  a_no_orphan_rsp : assert property (@(posedge clk) disable iff (reset)
    !(imem_rsp_valid && (outstanding == '0)));

endmodule
